// File: rtl/fir_avg_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fir_avg_stream
//  Purpose  : Multi-channel moving-average FIR with valid/ready streaming.
//             All channels share one circular write pointer and advance in
//             lock-step; bypass passes raw samples while history keeps
//             tracking the input.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_avg_stream #(
    parameter int DATA_W    = 24,
    parameter int CHANNELS  = 2,
    parameter int LOG2_TAPS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data
);

    localparam int TAPS  = 1 << LOG2_TAPS;
    // LOG2_TAPS guard bits make the running sum of TAPS samples overflow-free.
    localparam int SUM_W = DATA_W + LOG2_TAPS;

    logic [DATA_W-1:0]          hist_q [CHANNELS][TAPS];
    logic signed [SUM_W-1:0]    sum_q  [CHANNELS];
    logic [LOG2_TAPS-1:0]       wp_q;
    logic                       out_valid_q;
    logic [CHANNELS*DATA_W-1:0] out_data_q;

    logic signed [SUM_W-1:0]    sum_d  [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] frame_d;
    logic                       accept;

    // Ready depends only on output-register state and flush, never on in_valid.
    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Per-channel running-sum update and output selection for this frame.
    always_comb begin
        frame_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_d[c] = sum_q[c]
                     - {{LOG2_TAPS{hist_q[c][wp_q][DATA_W-1]}}, hist_q[c][wp_q]}
                     + {{LOG2_TAPS{in_data[c*DATA_W+DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
            // Arithmetic shift floors toward minus infinity; the mean always fits DATA_W.
            frame_d[c*DATA_W +: DATA_W] = enable ? DATA_W'(sum_d[c] >>> LOG2_TAPS)
                                                 : in_data[c*DATA_W +: DATA_W];
        end
    end

    // History, sums, pointer and the one-deep output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
            wp_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
            wp_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            // History advances even in bypass so re-enabling has no transient.
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c]        <= sum_d[c];
                hist_q[c][wp_q] <= in_data[c*DATA_W +: DATA_W];
            end
            wp_q        <= wp_q + LOG2_TAPS'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= frame_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_avg_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_avg_stream
//  Purpose  : Directed self-checking bench for fir_avg_stream (defaults:
//             24-bit samples, 2 channels, 8 taps).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_avg_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    fir_avg_stream #(
        .DATA_W   (24),
        .CHANNELS (2),
        .LOG2_TAPS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack(input int c0, input int c1);
        return {c1[23:0], c0[23:0]};
    endfunction

    function automatic logic [23:0] s24(input int v);
        return v[23:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one output frame: valid high and both channel values.
    task automatic chk_frame(input string tag, input int e0, input int e1);
        chk({tag, " valid"}, {47'd0, out_valid}, 48'd1);
        chk({tag, " ch0"}, {24'd0, out_data[23:0]},  {24'd0, s24(e0)});
        chk({tag, " ch1"}, {24'd0, out_data[47:24]}, {24'd0, s24(e1)});
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("reset out_valid", {47'd0, out_valid}, 48'd0);
        chk("reset out_data", out_data, 48'd0);
        chk("reset in_ready", {47'd0, in_ready}, 48'd1);

        // Step response: ch0 ramps to 800, ch1 floors down to -8.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = pack(800, -8);
            step();
            chk_frame($sformatf("step%0d", i), 100 * ((i < 7) ? i + 1 : 8),
                      -((i < 7) ? i + 1 : 8));
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", {47'd0, out_valid}, 48'd0);
        do_flush();

        // Negative impulse keeps floor(-1/8) = -1 for eight frames.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = pack((i == 0) ? -1 : 0, 0);
            step();
            chk_frame($sformatf("nimp%0d", i), (i < 8) ? -1 : 0, 0);
        end
        // Positive impulse floors to zero throughout.
        for (int i = 0; i < 9; i++) begin
            in_data = pack((i == 0) ? 1 : 0, 0);
            step();
            chk_frame($sformatf("pimp%0d", i), 0, 0);
        end
        do_flush();

        // Backpressure: output held while out_ready is low.
        in_valid = 1'b1;
        in_data  = pack(800, 0);
        step();
        chk_frame("bp first", 100, 0);
        out_ready = 1'b0;
        in_data   = pack(4000, 0);
        #1;
        chk("bp in_ready low", {47'd0, in_ready}, 48'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_frame($sformatf("bp hold%0d", i), 100, 0);
            chk($sformatf("bp in_ready%0d", i), {47'd0, in_ready}, 48'd0);
        end
        out_ready = 1'b1;
        in_data   = pack(800, 0);
        #1;
        chk("bp in_ready high", {47'd0, in_ready}, 48'd1);
        step();
        chk_frame("bp swap", 200, 0);
        in_valid = 1'b0;
        step();
        chk("bp consumed", {47'd0, out_valid}, 48'd0);
        do_flush();

        // Bypass passes raw samples.
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = pack(1234, -5);
        step();
        chk_frame("bypass raw", 1234, -5);
        do_flush();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = pack(800, 0);
            step();
            chk_frame($sformatf("bypass%0d", i), 800, 0);
        end
        enable = 1'b1;
        step();
        chk_frame("switch filtered", 800, 0);
        do_flush();

        // Extremes: full-scale positive and negative average without wrap.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = pack(32'h007F_FFFF, -8388608);
            step();
            if (i == 0) chk_frame("ext ramp", 32'h000F_FFFF, -1048576);
        end
        chk_frame("ext settled", 32'h007F_FFFF, -8388608);

        // Flush mid-stream with valid input present.
        flush = 1'b1;
        #1;
        chk("flush in_ready", {47'd0, in_ready}, 48'd0);
        step();
        chk("flush out_valid", {47'd0, out_valid}, 48'd0);
        chk("flush out_data", out_data, 48'd0);
        flush   = 1'b0;
        in_data = pack(800, 0);
        step();
        chk_frame("post flush", 100, 0);

        // Asynchronous reset mid-stream, mid-cycle.
        step();
        chk_frame("pre reset", 200, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", {47'd0, out_valid}, 48'd0);
        chk("async reset out_data", out_data, 48'd0);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("reset release in_ready", {47'd0, in_ready}, 48'd1);
        step();
        chk_frame("post reset", 100, 0);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_avg_stream.md
# fir_avg_stream

Parametrised multi-channel moving-average FIR filter with valid/ready streaming handshake, sitting between the audio codec's read port (readdata_*, read_ready/read) and its write port (writedata_*, write_ready/write). It replaces free-running per-channel filters: one instance filters all channels in lock-step. It accepts one sample frame per handshake and produces one filtered frame per accepted input. A bypass mode passes samples through while keeping the filter history current.

## Interface
- DATA_W, 24, sample width per channel, signed two's complement
- CHANNELS, 2, number of channels, ≥1; channel c occupies bits [c*DATA_W +: DATA_W]
- LOG2_TAPS, 3, log2 of tap count, range 1..6; TAPS = 2**LOG2_TAPS

- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = filtered output, 0 = bypass (raw input to output)
- flush  in  1  synchronous clear of history and output register
- in_valid  in  1  input frame present (driven from read_ready)
- in_ready  out  1  block can accept a frame this cycle (drives codec read)
- in_data  in  CHANNELS*DATA_W  input frame
- out_valid  out  1  output frame present (drives codec write)
- out_ready  in  1  downstream accepts frame (write_ready)
- out_data  out  CHANNELS*DATA_W  output frame

## Operation
- Per channel: TAPS-deep history buffer (circular, shared write pointer wp), accumulator sum of width DATA_W+LOG2_TAPS.
- Accept = in_valid && in_ready. On accept, per channel: x = sign-extended input, old = hist[wp]; sum_next = sum − old + x; hist[wp] = x; output = enable ? (sum_next >>> LOG2_TAPS, truncated to DATA_W) : x.
- Division is arithmetic shift right (floor toward −∞). Accumulator width guarantees no overflow; result always fits DATA_W.
- wp increments on every accept, wraps TAPS−1 → 0.
- History and sum update on every accept regardless of enable; toggling enable changes only the next output selection, no transient.
- enable is sampled in the accept cycle only.
- History starts at zero: first TAPS outputs ramp (averaged with zeros).
- Output register: one frame deep. in_ready = !flush && (!out_valid || out_ready) (combinational).
- Output register load on accept sets out_valid=1; out_valid clears when out_ready && !accept.
- Simultaneous out_ready and accept: old frame consumed, new frame loaded, out_valid stays 1.
- out_data stable while out_valid && !out_ready.
- flush (synchronous, highest priority): all history, sums, wp ← 0; out_valid ← 0; out_data ← 0; no accept in that cycle.

## Timing
- Reset (async assert, any time including mid-stream): history, sum, wp = 0; out_valid = 0; out_data = 0; in_ready = 1 once reset deasserts (with flush = 0).
- Latency: accept in cycle k → out_valid = 1 and out_data valid in cycle k+1.
- Throughput: one frame per cycle when out_ready held high.
- No combinational path from in_valid to in_ready; in_ready depends on out_valid, out_ready, flush only.

## Test plan
- Reset: assert reset mid-stream with out_valid=1 → out_valid=0, out_data=0, in_ready=1 immediately after deassert; next constant 800 input gives 100 (history cleared).
- Step (defaults, enable=1, out_ready=1): ch0 constant 800, ch1 constant −8 for 10 frames → ch0 outputs 100,200,…,800,800,800; ch1 outputs −1,−2,…,−8,−8,−8.
- Impulse/floor: single −1 on ch0 then zeros → output −1 for 8 frames (floor), then 0; +1 impulse → 0 throughout.
- Backpressure: accept one frame, hold out_ready=0 → in_ready=0, out_data unchanged for 5 cycles; raise out_ready with in_valid=1 same cycle → old frame consumed, new frame accepted, out_valid stays 1.
- Bypass/switch: enable=0, inputs 1234 → output 1234 next cycle; after 8 frames of 800 in bypass, set enable=1 → first filtered output exactly 800.
- Extremes + flush: constant 0x7FFFFF → settles to 0x7FFFFF, constant 0x800000 → 0x800000 (no wrap); assert flush mid-stream → out_valid=0, in_ready=0 that cycle, next 800 input gives 100.
